// File: rtl/mult_accumulator_if.sv
// Handshake bundle between the multiplier stage, the accumulator and its consumer.
// master = job/product source and result consumer; slave = the accumulator.
interface mult_accumulator_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned MAX_TERMS = 16
);
   localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   logic             start;
   logic [CNT_W-1:0] num_terms;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    product;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] result;
   logic             overflow;

   modport master (
      output start, num_terms, in_valid, product, out_ready,
      input  busy, in_ready, out_valid, result, overflow
   );

   modport slave (
      input  start, num_terms, in_valid, product, out_ready,
      output busy, in_ready, out_valid, result, overflow
   );
endinterface

// File: rtl/mult_accumulator.sv
// Saturating multiply-accumulate stage: sums a programmed number of signed
// products from the Booth multiplier and returns the sum plus a sticky overflow flag.
module mult_accumulator #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_W     = 24,
   parameter int unsigned MAX_TERMS = 16
) (
   input logic               clk,
   input logic               rst,
   mult_accumulator_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned EXT_W = ACC_W + 1 - PW;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] n_q, n_d;

   logic [ACC_W:0]   sum_c;
   logic [CNT_W-1:0] n_clamp_c;

   // One guard bit above the accumulator exposes overflow as a sign-bit disagreement.
   assign sum_c     = {acc_q[ACC_W-1], acc_q} + {{EXT_W{bus.product[PW-1]}}, bus.product};
   assign n_clamp_c = (bus.num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : bus.num_terms;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               n_d     = n_clamp_c;
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = (n_clamp_c == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (bus.in_valid) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
                  ovf_d = 1'b1;
                  acc_d = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
               end else begin
                  acc_d = sum_c[ACC_W-1:0];
               end
               if (cnt_q == n_q - CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decode from the state register only.
   assign bus.in_ready  = (state_q == S_ACCUM);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.result    = acc_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: a driver issues jobs and queues the model's expected
// sum; an independent monitor pops and compares whenever a result is accepted.
module tb_mult_accumulator;
   localparam int unsigned WIDTH     = 8;
   localparam int unsigned ACC_W     = 18;
   localparam int unsigned MAX_TERMS = 16;
   localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1);
   localparam int unsigned PW        = 2 * WIDTH;
   localparam longint      ACC_MAXV  = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint      ACC_MINV  = -(longint'(1) <<< (ACC_W - 1));

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_accumulator_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) bus ();

   mult_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      longint res;
      bit     ovf;
   } exp_t;

   exp_t sb_q[$];
   int   prods[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer running sum, clamped to the signed ACC_W range after each term.
   function automatic longint model(input int cnt, output bit ovf);
      longint acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < cnt; i++) begin
         acc = acc + longint'(prods[i]);
         if (acc > ACC_MAXV) begin acc = ACC_MAXV; ovf = 1'b1; end
         if (acc < ACC_MINV) begin acc = ACC_MINV; ovf = 1'b1; end
      end
      return acc;
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_result", $signed(bus.result), e.res);
            check("sb_overflow", bus.overflow, e.ovf);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic run_job(input int nt, input int gap_min, input int gap_max, input int bp_cycles);
      int     n;
      int     idx;
      int     budget;
      int     g;
      bit     rdy;
      bit     eo;
      bit     po;
      longint er;
      longint pe;
      exp_t   e;
      n  = (nt > int'(MAX_TERMS)) ? int'(MAX_TERMS) : nt;
      er = model(n, eo);
      e.res = er;
      e.ovf = eo;
      sb_q.push_back(e);

      bus.start     = 1'b1;
      bus.num_terms = CNT_W'(nt);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == 0) check("zero_terms_out_valid", bus.out_valid, 1);

      idx    = 0;
      budget = 0;
      while (!bus.out_valid && budget < 2000) begin
         budget++;
         g = $urandom_range(gap_max, gap_min);
         repeat (g) begin
            bus.in_valid  = 1'b0;
            bus.product   = PW'($urandom);
            bus.start     = 1'($urandom_range(1, 0));
            bus.num_terms = CNT_W'($urandom);
            @(posedge clk); #1;
         end
         bus.start = 1'b0;
         if (g > 0) begin
            pe = model(idx, po);
            check("gap_acc_hold", $signed(bus.result), pe);
         end
         bus.in_valid = 1'b1;
         bus.product  = PW'((idx < prods.size()) ? prods[idx] : 0);
         rdy = bus.in_ready;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         if (rdy) idx++;
         if (rdy && idx == n) check("last_beat_latency", bus.out_valid, 1);
      end
      bus.start = 1'b0;
      if (budget >= 2000) check("accum_timeout", 0, 1);
      check("beats_accepted", idx, n);

      repeat (bp_cycles) begin
         bus.start     = 1'b1;
         bus.num_terms = CNT_W'($urandom);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_busy", bus.busy, 1);
         check("bp_result", $signed(bus.result), er);
         check("bp_overflow", bus.overflow, eo);
         @(posedge clk); #1;
      end

      // Start alongside the accepting out_ready must not relaunch a job.
      bus.start     = 1'b1;
      bus.num_terms = CNT_W'(3);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      check("release_out_valid", bus.out_valid, 0);
      check("release_busy", bus.busy, 0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.num_terms = '0;
      bus.in_valid  = 1'b0;
      bus.product   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_result", $signed(bus.result), 0);
      check("rst_overflow", bus.overflow, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      prods = '{100, -50, 7};
      run_job(3, 0, 0, 0);

      prods = '{1, 2, 3, 4};
      run_job(4, 2, 2, 0);

      prods.delete();
      repeat (16) prods.push_back(16384);
      run_job(16, 0, 0, 0);
      prods.delete();
      repeat (16) prods.push_back(-16256);
      run_job(16, 0, 0, 0);
      prods.delete();
      repeat (16) prods.push_back(8000);
      run_job(16, 0, 1, 0);

      prods = '{-300, 200, 55};
      run_job(3, 0, 0, 5);

      prods.delete();
      run_job(0, 0, 0, 2);

      prods.delete();
      for (int i = 0; i < 20; i++) prods.push_back(i * 37 - 200);
      run_job(31, 0, 0, 0);

      // Asynchronous reset mid-job: two of five beats, then reset between clock edges.
      prods = '{11, 22, 33, 44, 55};
      bus.start     = 1'b1;
      bus.num_terms = CNT_W'(5);
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.product  = PW'(prods[i]);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", bus.busy, 0);
      check("async_rst_in_ready", bus.in_ready, 0);
      check("async_rst_out_valid", bus.out_valid, 0);
      check("async_rst_result", $signed(bus.result), 0);
      check("async_rst_overflow", bus.overflow, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      prods = '{5, 6};
      run_job(2, 0, 0, 0);

      for (int j = 0; j < 25; j++) begin
         int nt;
         nt = $urandom_range(20, 0);
         prods.delete();
         for (int i = 0; i < 20; i++) begin
            if (j % 2 == 0) prods.push_back(int'($signed(PW'($urandom))));
            else            prods.push_back(int'($urandom_range(400, 0)) - 200);
         end
         run_job(nt, 0, $urandom_range(3, 0), $urandom_range(3, 0));
      end

      repeat (5) @(posedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Sequential accumulate stage placed directly downstream of the combinational radix-4 Booth multiplier. It consumes a stream of signed 2*WIDTH-bit products over a valid/ready handshake and sums a programmed number of them into a saturating ACC_W-bit accumulator. It then presents the sum and a sticky overflow flag on an output valid/ready handshake, giving the ALU a multiply-accumulate (dot-product) path.

Parameters:
WIDTH, 8, operand width of the upstream multiplier; the product input is 2*WIDTH bits.
ACC_W, 24, accumulator/result width; must be >= 2*WIDTH.
MAX_TERMS, 16, maximum number of products summed per job.
CNT_W, $clog2(MAX_TERMS+1), width of num_terms and the internal term counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  one-cycle job launch; sampled only in IDLE.
num_terms  input  CNT_W  products in this job; captured on accepted start.
busy  output  1  high in ACCUM and DONE.
in_valid  input  1  product valid from multiplier stage.
in_ready  output  1  accumulator accepts product this cycle.
product  input  2*WIDTH  signed product (two's complement).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  ACC_W  signed accumulated sum.
overflow  output  1  sticky; saturation occurred during this job.

Behaviour:
- Reset is asynchronous and active-high. Reset clears state to IDLE, acc/result to 0, overflow to 0, the counter to 0 and the captured term count to 0. in_ready, out_valid and busy are 0. Reset asserted mid-job aborts the job; no partial result is emitted.
- States: IDLE, ACCUM, DONE. in_ready, out_valid and busy decode from the registered state only, with no combinational input-to-output path.
- IDLE: in_ready=0, out_valid=0. When start=1:
  - Capture n = min(num_terms, MAX_TERMS); clear acc, overflow and cnt.
  - n==0: go to DONE with result 0.
  - Otherwise: go to ACCUM.
- ACCUM: in_ready=1. A beat transfers on in_valid & in_ready.
  - Per beat: acc <= sat(acc + sext(product)); cnt <= cnt+1.
  - On the beat where cnt==n-1, go to DONE. out_valid is high the cycle after that beat's edge, i.e. one cycle of latency.
  - Cycles with in_valid=0 change nothing. start is ignored.
- DONE: out_valid=1; result and overflow hold stable.
  - On out_ready=1, return to IDLE at that edge.
  - start in DONE is ignored, even in the cycle out_ready=1. A new job needs start in IDLE.
- Arithmetic: product is sign-extended to ACC_W+1 bits and added to the sign-extended acc.
  - Sum > 2^(ACC_W-1)-1: acc = 2^(ACC_W-1)-1, overflow <= 1.
  - Sum < -2^(ACC_W-1): acc = -2^(ACC_W-1), overflow <= 1.
  - Later beats add to the saturated value. overflow never clears within a job.
- result mirrors acc. Its value outside DONE is don't-care for consumers but must be deterministic: 0 after reset.
- num_terms > MAX_TERMS clamps to MAX_TERMS.

Test Plan:
- Basic: start with num_terms=3; products 100, -50, 7 with in_valid back-to-back -> out_valid high the cycle after the 3rd beat, result=57, overflow=0; out_ready=1 -> IDLE.
- Stalls: num_terms=4; products 1, 2, 3, 4 with in_valid low 2 cycles between each -> result=10; acc unchanged during gaps.
- Saturation (ACC_W=18): 16 x 16384 -> result=131071, overflow=1. 16 x -16256 -> result=-131072, overflow=1. 16 x 8000 -> result=128000, overflow=0.
- Backpressure: in DONE hold out_ready=0 for 5 cycles -> out_valid, result and overflow stable; in_ready=0; start pulses ignored.
- Edge counts: num_terms=0 -> out_valid next cycle, result=0. num_terms=31 (MAX 16) -> exactly 16 beats accepted before DONE.
- Reset mid-job: assert rst asynchronously after 2 of 5 beats -> outputs 0 immediately without waiting for a clock edge. A following job with num_terms=2 and products 5, 6 -> result=11.
